// File: rtl/crypt_pkg.sv
// crypt_pkg: mode encoding, byte rotations and round-key derivation shared by the cipher pipeline
package crypt_pkg;
  typedef enum logic {CRYPT_ENC = 1'b0, CRYPT_DEC = 1'b1} crypt_mode_e;
  localparam int KEY_MAX = 1024;
  function automatic logic [7:0] rotl8(input logic [7:0] x);
    return {x[6:0], x[7]};
  endfunction
  function automatic logic [7:0] rotr8(input logic [7:0] x);
    return {x[0], x[7:1]};
  endfunction
  // key arrives zero-extended to KEY_MAX; kbytes is the real key width in bytes
  function automatic logic [7:0] round_key(input logic [KEY_MAX-1:0] key, input logic [7:0] r, input int kbytes);
    return key[8*(int'(r) % kbytes) +: 8] ^ r;
  endfunction
endpackage

// File: rtl/crypt_round.sv
// crypt_round: one combinational cipher round, direction chosen by the beat's own mode
module crypt_round
  import crypt_pkg::*;
#(
  parameter int NBYTES = 16,
  parameter int KEY_W  = 32
) (
  input  crypt_mode_e             mode,
  input  logic [7:0]              rnd,
  input  logic [KEY_W-1:0]        key,
  input  logic [8*NBYTES-1:0]     din,
  output logic [8*NBYTES-1:0]     dout
);
  logic [7:0] rk;
  always_comb begin
    rk = round_key(KEY_MAX'(key), rnd, KEY_W/8);
    dout = '0;
    for (int i = 0; i < NBYTES; i++)
      dout[8*i +: 8] = mode == CRYPT_DEC ? rotr8(din[8*((i+NBYTES-1)%NBYTES) +: 8]) ^ rk
                                         : rotl8(din[8*((i+1)%NBYTES) +: 8] ^ rk);
  end
endmodule

// File: rtl/crypt_pipe_param.sv
// crypt_pipe_param: per-beat-mode pipelined cipher, one round per stage, global stall flow control.
// Optional CRYPT_STATS_EN adds saturating enc_count/dec_count of consumed results.
module crypt_pipe_param
  import crypt_pkg::*;
#(
  parameter int NBYTES  = 16,
  parameter int NROUNDS = 4,
  parameter int KEY_W   = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_mode,
  input  logic [KEY_W-1:0]    in_key,
  input  logic [8*NBYTES-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_mode,
  output logic [8*NBYTES-1:0] out_data
`ifdef CRYPT_STATS_EN
  ,
  output logic [15:0]         enc_count,
  output logic [15:0]         dec_count
`endif
);
  localparam int DW = 8*NBYTES;
  // the final stage's key feeds nothing downstream, so only the first NROUNDS-1 stages keep one
  localparam int KS = NROUNDS > 1 ? NROUNDS-1 : 1;
  logic stall;
  logic [NROUNDS-1:0] valid_q, valid_d, mode_q, mode_d, src_valid, src_mode;
  logic [KS-1:0][KEY_W-1:0] key_q, key_d;
  logic [NROUNDS-1:0][KEY_W-1:0] src_key;
  logic [NROUNDS-1:0][DW-1:0] data_q, data_d, src_data, rnd_data;
  assign stall     = valid_q[NROUNDS-1] & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = valid_q[NROUNDS-1];
  assign out_mode  = mode_q[NROUNDS-1];
  assign out_data  = data_q[NROUNDS-1];
  for (genvar s = 0; s < NROUNDS; s++) begin : g_stage
    if (s == 0) begin : g_head
      // idle input slots load zeros so bubbles never carry X to the outputs
      assign src_valid[0] = in_valid;
      assign src_mode[0]  = in_valid & in_mode;
      assign src_key[0]   = in_valid ? in_key : '0;
      assign src_data[0]  = in_valid ? in_data : '0;
    end else begin : g_link
      assign src_valid[s] = valid_q[s-1];
      assign src_mode[s]  = mode_q[s-1];
      assign src_key[s]   = key_q[s-1];
      assign src_data[s]  = data_q[s-1];
    end
    crypt_round #(.NBYTES(NBYTES), .KEY_W(KEY_W)) u_round (
      .mode (crypt_mode_e'(src_mode[s])),
      .rnd  (src_mode[s] ? 8'(NROUNDS-1-s) : 8'(s)),
      .key  (src_key[s]),
      .din  (src_data[s]),
      .dout (rnd_data[s])
    );
  end
  always_comb begin
    valid_d = stall ? valid_q : src_valid;
    mode_d  = stall ? mode_q : src_mode;
    key_d   = stall ? key_q : src_key[KS-1:0];
    data_d  = stall ? data_q : rnd_data;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= '0;
      mode_q  <= '0;
      key_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      mode_q  <= mode_d;
      key_q   <= key_d;
      data_q  <= data_d;
    end
  end
`ifdef CRYPT_STATS_EN
  logic [15:0] enc_q, enc_d, dec_q, dec_d;
  logic fire;
  always_comb begin
    fire  = out_valid & out_ready;
    enc_d = enc_q + 16'(fire & ~out_mode & (enc_q != 16'hFFFF));
    dec_d = dec_q + 16'(fire & out_mode & (dec_q != 16'hFFFF));
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      enc_q <= '0;
      dec_q <= '0;
    end else begin
      enc_q <= enc_d;
      dec_q <= dec_d;
    end
  end
  assign enc_count = enc_q;
  assign dec_count = dec_q;
`endif
endmodule

// File: tb/tb_crypt_pipe_param.sv
// tb_crypt_pipe_param: scoreboard bench for crypt_pipe_param; stats checks need CRYPT_STATS_EN
module tb_crypt_pipe_param;
  localparam int NB = 16, NR = 4, KW = 32, DW = 8*NB;
  logic clk = 0, reset = 0, in_valid = 0, in_mode = 0, out_ready = 1;
  logic in_ready, out_valid, out_mode;
  logic [KW-1:0] in_key = '0;
  logic [DW-1:0] in_data = '0, out_data;
`ifdef CRYPT_STATS_EN
  logic [15:0] enc_count, dec_count;
`endif
  int checks = 0, errors = 0, out_cnt = 0;
  logic [DW:0] sb[$];
  logic [DW:0] exp_beat;

  always #5 clk = ~clk;

  crypt_pipe_param #(.NBYTES(NB), .NROUNDS(NR), .KEY_W(KW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_key(in_key), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_mode(out_mode), .out_data(out_data)
`ifdef CRYPT_STATS_EN
    , .enc_count(enc_count), .dec_count(dec_count)
`endif
  );

  function automatic logic [7:0] rl(input logic [7:0] x);
    return (x << 1) | (x >> 7);
  endfunction
  function automatic logic [7:0] rr(input logic [7:0] x);
    return (x >> 1) | (x << 7);
  endfunction
  function automatic logic [DW-1:0] model(input logic m, input logic [KW-1:0] k, input logic [DW-1:0] d);
    logic [7:0] b[NB];
    logic [7:0] t[NB];
    logic [7:0] rk;
    logic [DW-1:0] o;
    int r;
    for (int i = 0; i < NB; i++) b[i] = d[8*i +: 8];
    for (int s = 0; s < NR; s++) begin
      r = m ? NR-1-s : s;
      rk = k[8*(r % (KW/8)) +: 8] ^ 8'(r);
      if (!m) begin
        for (int i = 0; i < NB; i++) t[i] = rl(b[i] ^ rk);
        for (int i = 0; i < NB; i++) b[i] = t[(i+1) % NB];
      end else begin
        for (int j = 0; j < NB; j++) t[j] = b[(j+NB-1) % NB];
        for (int j = 0; j < NB; j++) b[j] = rr(t[j]) ^ rk;
      end
    end
    for (int i = 0; i < NB; i++) o[8*i +: 8] = b[i];
    return o;
  endfunction

  // scoreboard: every consumed result is popped and compared in order
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      checks++;
      out_cnt++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out got mode=%0b data=%h required no output", out_mode, out_data);
      end else begin
        exp_beat = sb.pop_front();
        if ({out_mode, out_data} !== exp_beat) begin
          errors++;
          $display("FAIL sb_out got mode=%0b data=%h required mode=%0b data=%h",
                   out_mode, out_data, exp_beat[DW], exp_beat[DW-1:0]);
        end
      end
    end
  end

  task automatic send(input logic m, input logic [KW-1:0] k, input logic [DW-1:0] d);
    int n = 0;
    in_valid = 1; in_mode = m; in_key = k; in_data = d;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_accept got in_ready=%0b required 1", in_ready);
    end else sb.push_back({m, model(m, k, d)});
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got pending=%0d required 0", sb.size());
    end
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
  endtask

  task automatic test_reset();
    reset = 0;
    repeat (2) @(posedge clk);
    #1;
    checks += 4;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b required 0", out_valid); end
    if (out_mode !== 1'b0) begin errors++; $display("FAIL rst_mode got %b required 0", out_mode); end
    if (out_data !== '0) begin errors++; $display("FAIL rst_data got %h required 0", out_data); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b required 1", in_ready); end
    reset = 1;
  endtask

  task automatic test_zero_latency();
    int n;
    out_ready = 1;
    send(0, '0, '0);
    wait_out(n);
    checks += 2;
    if (n != NR-1) begin errors++; $display("FAIL latency got %0d edges after accept required %0d", n, NR-1); end
    if (out_data !== {NB{8'h06}}) begin errors++; $display("FAIL zero_enc got %h required all 06", out_data); end
    wait_drain();
  endtask

  task automatic test_round_trip();
    logic [DW-1:0] pt = 128'h00112233445566778899AABBCCDDEEFF;
    logic [KW-1:0] k = 32'hA5C3_0F1E;
    logic [DW-1:0] ct;
    int n;
    send(0, k, pt);
    wait_out(n);
    ct = out_data;
    wait_drain();
    send(1, k, ct);
    wait_out(n);
    checks += 2;
    if (out_data !== pt) begin errors++; $display("FAIL round_trip got %h required %h", out_data, pt); end
    if (out_mode !== 1'b1) begin errors++; $display("FAIL round_trip_mode got %b required 1", out_mode); end
    wait_drain();
  endtask

  task automatic test_interleave();
    int c0 = out_cnt;
    logic [DW-1:0] d;
    for (int i = 0; i < 8; i++) begin
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      send(i[0], $urandom(), d);
    end
    wait_drain();
    checks++;
    if (out_cnt - c0 != 8) begin errors++; $display("FAIL interleave_count got %0d required 8", out_cnt - c0); end
  endtask

  task automatic test_backpressure();
    int c0 = out_cnt;
    logic [DW-1:0] d5 = {4{32'hDEAD_BEEF}};
    out_ready = 0;
    for (int i = 0; i < 4; i++) send(i[0], 32'h0102_0304 + i, {NB{8'(i)}});
    in_valid = 1; in_mode = 1; in_key = 32'h5555_AAAA; in_data = d5;
    for (int c = 0; c < 5; c++) begin
      checks += 3;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cycle %0d got %b required 0", c, in_ready); end
      if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid cycle %0d got %b required 1", c, out_valid); end
      if (out_data !== sb[0][DW-1:0]) begin
        errors++; $display("FAIL bp_hold cycle %0d got %h required %h", c, out_data, sb[0][DW-1:0]);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (out_cnt != c0) begin errors++; $display("FAIL bp_no_consume got %0d required 0", out_cnt - c0); end
    out_ready = 1;
    sb.push_back({1'b1, model(1, 32'h5555_AAAA, d5)});
    @(posedge clk); #1;
    in_valid = 0;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (out_cnt - c0 != 4) begin errors++; $display("FAIL bp_drain_rate got %0d required 4", out_cnt - c0); end
    wait_drain();
    checks++;
    if (out_cnt - c0 != 5) begin errors++; $display("FAIL bp_total got %0d required 5", out_cnt - c0); end
  endtask

  task automatic test_reset_mid();
    int c0;
    out_ready = 1;
    for (int i = 0; i < 3; i++) send(0, 32'h1111_1111 * (i+1), {NB{8'hA0 + 8'(i)}});
    reset = 0;
    sb.delete();
    @(posedge clk); #1;
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b required 0", out_valid); end
    if (out_data !== '0) begin errors++; $display("FAIL mid_rst_data got %h required 0", out_data); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_in_ready got %b required 1", in_ready); end
    reset = 1;
    c0 = out_cnt;
    repeat (6) begin @(posedge clk); #1; end
    checks++;
    if (out_cnt != c0) begin errors++; $display("FAIL mid_rst_flushed got %0d outputs required 0", out_cnt - c0); end
    send(1, 32'hCAFE_F00D, {NB{8'h3C}});
    wait_drain();
    checks++;
    if (out_cnt - c0 != 1) begin errors++; $display("FAIL mid_rst_next got %0d required 1", out_cnt - c0); end
  endtask

`ifdef CRYPT_STATS_EN
  task automatic test_stats();
    logic [DW:0] z = {1'b0, model(0, '0, '0)};
    reset = 0;
    @(posedge clk); #1;
    reset = 1;
    for (int i = 0; i < 5; i++) send(i >= 3, 32'h7777_0000 + i, {NB{8'(i)}});
    wait_drain();
    checks += 2;
    if (enc_count !== 16'd3) begin errors++; $display("FAIL enc_count got %0d required 3", enc_count); end
    if (dec_count !== 16'd2) begin errors++; $display("FAIL dec_count got %0d required 2", dec_count); end
    in_valid = 1; in_mode = 0; in_key = '0; in_data = '0;
    for (int i = 0; i < 70000; i++) begin
      sb.push_back(z);
      @(posedge clk); #1;
    end
    in_valid = 0;
    wait_drain();
    checks += 2;
    if (enc_count !== 16'hFFFF) begin errors++; $display("FAIL enc_sat got %h required FFFF", enc_count); end
    if (dec_count !== 16'd2) begin errors++; $display("FAIL dec_after_sat got %0d required 2", dec_count); end
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_zero_latency();
    test_round_trip();
    test_interleave();
    test_backpressure();
    test_reset_mid();
`ifdef CRYPT_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
